// File: rtl/vend_payout_if.sv
// Payout bundle: request pulses, drop sensors and fault clear in; motor drives and status out.
// Latency: pure wiring, no registers.
// Backpressure: none; requests that arrive while the queue is full are dropped and flagged.
interface vend_payout_if #(
  parameter int QDEPTH = 4
);
  localparam int PW = $clog2(QDEPTH + 1);

  logic          dispense_req;
  logic          change_req;
  logic          product_sensor;
  logic          coin_sensor;
  logic          fault_clr;
  logic          product_motor;
  logic          hopper_motor;
  logic          done;
  logic          busy;
  logic          fault;
  logic          overflow;
  logic [PW-1:0] pending;

  // Upstream/electromechanics side: drives requests and sensors, observes drives and status.
  modport master (
    output dispense_req, change_req, product_sensor, coin_sensor, fault_clr,
    input  product_motor, hopper_motor, done, busy, fault, overflow, pending
  );

  // Controller side.
  modport slave (
    input  dispense_req, change_req, product_sensor, coin_sensor, fault_clr,
    output product_motor, hopper_motor, done, busy, fault, overflow, pending
  );
endinterface

// File: rtl/vend_payout_ctrl.sv
// Queues dispense/change pulses and runs the product motor and coin hopper until drop sensors confirm.
// Latency: request in cycle N drives its motor from cycle N+2; done pulses one cycle after the final gap.
// Backpressure: none upstream; a request into a full queue is dropped and sets sticky overflow.
// Optional PAYOUT_RETRY_EN: a first motor timeout rests for a gap and retries the phase once.
module vend_payout_ctrl #(
  parameter int QDEPTH       = 4,
  parameter int MOTOR_CYCLES = 16,
  parameter int CHANGE_COINS = 1,
  parameter int GAP_CYCLES   = 4
) (
  input  logic        clk,
  input  logic        reset,
  vend_payout_if.slave bus
);
  localparam int PW = $clog2(QDEPTH + 1);
  localparam int AW = $clog2(QDEPTH);
  localparam int TW = $clog2(MOTOR_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int CW = $clog2(CHANGE_COINS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VEND,
    S_PAY,
    S_GAP,
    S_FAULT
  } state_t;

  state_t state, state_nx;

  // Request queue: each entry is {disp, chg}.
  logic [1:0]    mem [QDEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0] count;
  logic [1:0]    head;
  logic          push, push_ok, pop, fifo_empty, fifo_full, overflow_q;

  // Active entry and phase bookkeeping.
  logic          ent_disp, ent_chg;
  logic [CW-1:0] coin_cnt;
  logic [TW-1:0] tmr;
  logic [GW-1:0] gap_cnt;
  logic          prev_prod, prev_coin;
  logic          vend_hit, coin_hit, tmo, gap_last, motor_on, motor_tmo;
  logic          done_set, done_q, retry_avail;

  assign push       = bus.dispense_req | bus.change_req;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == PW'(QDEPTH));
  assign push_ok    = push & ~fifo_full;
  assign head       = mem[rd_ptr];

  // A sensor only counts on its rising edge and only while its own motor runs.
  assign vend_hit  = (state == S_VEND) & bus.product_sensor & ~prev_prod;
  assign coin_hit  = (state == S_PAY)  & bus.coin_sensor    & ~prev_coin;
  assign motor_on  = (state == S_VEND) | (state == S_PAY);
  assign tmo       = (tmr == TW'(MOTOR_CYCLES - 1));
  assign motor_tmo = motor_on & tmo & ~vend_hit & ~coin_hit;
  assign gap_last  = (gap_cnt == GW'(GAP_CYCLES - 1));

  // Queue storage, pointers, occupancy and sticky overflow; a full queue drops even on a pop cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < QDEPTH; i++) mem[i] <= 2'b00;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= {bus.dispense_req, bus.change_req};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push & fifo_full) overflow_q <= 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef PAYOUT_RETRY_EN
  logic retry_used;

  // One retry per entry; any successful drop re-arms it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) retry_used <= 1'b0;
    else if (pop | vend_hit | coin_hit) retry_used <= 1'b0;
    else if (motor_tmo) retry_used <= 1'b1;
  end

  assign retry_avail = ~retry_used;
`else
  assign retry_avail = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next state, head pop and end-of-entry detection.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    done_set = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          state_nx = head[1] ? S_VEND : S_PAY;
        end
      end
      S_VEND: begin
        if (vend_hit)  state_nx = S_GAP;
        else if (tmo)  state_nx = retry_avail ? S_GAP : S_FAULT;
      end
      S_PAY: begin
        if (coin_hit)  state_nx = S_GAP;
        else if (tmo)  state_nx = retry_avail ? S_GAP : S_FAULT;
      end
      S_GAP: begin
        if (gap_last) begin
          // Product first (also covers a retried vend), then coins until the quota is met.
          if (ent_disp) begin
            state_nx = S_VEND;
          end else if (ent_chg && (coin_cnt < CW'(CHANGE_COINS))) begin
            state_nx = S_PAY;
          end else begin
            done_set = 1'b1;
            state_nx = S_IDLE;
          end
        end
      end
      S_FAULT: begin
        if (bus.fault_clr) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Phase timers and sensor history; every motor phase is entered from a motor-off state, so both start at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmr       <= '0;
      gap_cnt   <= '0;
      prev_prod <= 1'b0;
      prev_coin <= 1'b0;
    end else begin
      tmr       <= motor_on ? tmr + 1'b1 : '0;
      gap_cnt   <= ((state == S_GAP) && !gap_last) ? gap_cnt + 1'b1 : '0;
      prev_prod <= (state == S_VEND) & bus.product_sensor;
      prev_coin <= (state == S_PAY)  & bus.coin_sensor;
    end
  end

  // Active entry: loaded on pop, product bit cleared on a drop, coins counted per drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_disp <= 1'b0;
      ent_chg  <= 1'b0;
      coin_cnt <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= done_set;
      if (pop) begin
        ent_disp <= head[1];
        ent_chg  <= head[0];
        coin_cnt <= '0;
      end else begin
        if (vend_hit) ent_disp <= 1'b0;
        if (coin_hit) coin_cnt <= coin_cnt + 1'b1;
      end
    end
  end

  assign bus.product_motor = (state == S_VEND);
  assign bus.hopper_motor  = (state == S_PAY);
  assign bus.fault         = (state == S_FAULT);
  assign bus.busy          = (state != S_IDLE) | ~fifo_empty;
  assign bus.done          = done_q;
  assign bus.overflow      = overflow_q;
  assign bus.pending       = count;
endmodule

// File: tb/tb_vend_payout_ctrl.sv
// Bench for vend_payout_ctrl: directed scenarios plus random traffic against a work-list model.
// Latency: outputs sampled at falling edges, inputs driven at falling edges.
// Backpressure: none; model tracks queue drops the same way the controller must.
module tb_vend_payout_ctrl;
  localparam int QD = 4;
  localparam int MC = 16;
  localparam int CC = 2;
  localparam int GC = 4;
`ifdef PAYOUT_RETRY_EN
  localparam int RETRIES = 1;
`else
  localparam int RETRIES = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  vend_payout_if #(.QDEPTH(QD)) bus ();

  vend_payout_ctrl #(
    .QDEPTH(QD), .MOTOR_CYCLES(MC), .CHANGE_COINS(CC), .GAP_CYCLES(GC)
  ) dut (
    .clk(clk),
    .reset(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nbad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: queue of entries + work list of the active entry
  typedef enum int {M_IDLE, M_RUN, M_REST, M_HALT} mmode_t;
  int     q[$];
  int     work[$];          // 1 = one product drop, 2 = one coin drop
  mmode_t mm = M_IDLE;
  int     age = 0, rest_left = 0, tries = RETRIES, m_pre = 0, m_e = 0;
  bit     prev_s = 0, m_s = 0, ovf_m = 0, done_m = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete(); work.delete();
      mm = M_IDLE; age = 0; rest_left = 0; tries = RETRIES;
      prev_s = 0; ovf_m = 0; done_m = 0;
    end else begin
      m_pre  = q.size();
      done_m = 0;
      case (mm)
        M_IDLE: if (m_pre > 0) begin
          m_e = q.pop_front();
          work.delete();
          if ((m_e & 2) != 0) work.push_back(1);
          if ((m_e & 1) != 0) repeat (CC) work.push_back(2);
          mm = M_RUN; age = 0; prev_s = 0; tries = RETRIES;
        end
        M_RUN: begin
          m_s = (work[0] == 1) ? bus.product_sensor : bus.coin_sensor;
          if (m_s && !prev_s) begin
            m_e = work.pop_front();
            tries = RETRIES; mm = M_REST; rest_left = GC;
          end else if (age == MC - 1) begin
            if (tries > 0) begin tries--; mm = M_REST; rest_left = GC; end
            else begin mm = M_HALT; work.delete(); end
          end else begin
            age++; prev_s = m_s;
          end
        end
        M_REST: begin
          rest_left--;
          if (rest_left == 0) begin
            if (work.size() > 0) begin mm = M_RUN; age = 0; prev_s = 0; end
            else begin done_m = 1; mm = M_IDLE; end
          end
        end
        M_HALT: if (bus.fault_clr) mm = M_IDLE;
        default: mm = M_IDLE;
      endcase
      if (bus.dispense_req || bus.change_req) begin
        if (m_pre == QD) ovf_m = 1;
        else q.push_back(int'({bus.dispense_req, bus.change_req}));
      end
    end
  end

  // ---------------- per-cycle compare against the model
  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("product_motor", int'(bus.product_motor),
          int'(mm == M_RUN && work.size() > 0 && work[0] == 1));
      chk("hopper_motor", int'(bus.hopper_motor),
          int'(mm == M_RUN && work.size() > 0 && work[0] == 2));
      chk("fault", int'(bus.fault), int'(mm == M_HALT));
      chk("busy", int'(bus.busy), int'(mm != M_IDLE || q.size() > 0));
      chk("done", int'(bus.done), int'(done_m));
      chk("overflow", int'(bus.overflow), int'(ovf_m));
      chk("pending", int'(bus.pending), q.size());
    end
  end

  // ---------------- stimulus helpers
  bit resp_en = 0, rnd_en = 0;
  int resp_delay = 3;
  int pon = 0, con = 0;
  bit o_pm, o_hm, o_done, o_busy, o_fault, o_ovf, p_pm = 0, p_hm = 0;
  int o_pend;
  int n_done = 0, n_vph = 0, n_cph = 0;

  // Samples the current cycle's outputs, then drives this cycle's inputs.
  task automatic step(input bit d, input bit c, input bit clr);
    @(negedge clk);
    o_pm = bus.product_motor; o_hm = bus.hopper_motor; o_done = bus.done;
    o_busy = bus.busy; o_fault = bus.fault; o_ovf = bus.overflow; o_pend = int'(bus.pending);
    if (o_pm && !p_pm) n_vph++;
    if (o_hm && !p_hm) n_cph++;
    if (o_done) n_done++;
    p_pm = o_pm; p_hm = o_hm;
    pon = o_pm ? pon + 1 : 0;
    con = o_hm ? con + 1 : 0;
    bus.dispense_req = d; bus.change_req = c; bus.fault_clr = clr;
    if (resp_en) begin
      bus.product_sensor = (pon == resp_delay);
      bus.coin_sensor    = (con == resp_delay);
    end else if (rnd_en) begin
      bus.product_sensor = bus.product_sensor ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 11) == 0);
      bus.coin_sensor    = bus.coin_sensor    ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 11) == 0);
    end
  endtask

  task automatic run_idle(input string nm, input int budget);
    int k = 0;
    do begin step(0, 0, 0); k++; end while (o_busy && k < budget);
    chk(nm, int'(o_busy), 0);
  endtask

  task automatic clr_counts();
    n_done = 0; n_vph = 0; n_cph = 0;
  endtask

  initial begin
    int first_on, on_cnt, done_at, hold;
    bit held;
    bus.dispense_req = 0; bus.change_req = 0; bus.fault_clr = 0;
    bus.product_sensor = 0; bus.coin_sensor = 0;
    repeat (3) @(negedge clk);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_pending", int'(bus.pending), 0);
    chk("reset_motors", int'({bus.product_motor, bus.hopper_motor}), 0);
    rst = 0;
    chk_en = 1;

    // 1: single dispense, sensor in cycle 5
    first_on = -1; on_cnt = 0; done_at = -1;
    for (int k = 0; k < 16; k++) begin
      step(k == 0, 0, 0);
      bus.product_sensor = (k == 5);
      if (o_pm) begin on_cnt++; if (first_on < 0) first_on = k; end
      if (o_done) done_at = k;
    end
    chk("t1_first_motor_cycle", first_on, 2);
    chk("t1_motor_cycles", on_cnt, 4);
    chk("t1_done_cycle", done_at, 5 + GC + 1);
    chk("t1_busy_after", int'(o_busy), 0);

    // 2: dispense+change together -> one entry, vend then coins, one done
    clr_counts();
    step(1, 1, 0);
    step(0, 0, 0);
    chk("t2_pending", o_pend, 1);
    resp_en = 1; resp_delay = 2;
    run_idle("t2_idle", 200);
    chk("t2_dones", n_done, 1);
    chk("t2_vend_phases", n_vph, 1);
    chk("t2_coin_phases", n_cph, CC);

    // 3: five requests while the first vend is stalled -> overflow
    clr_counts();
    resp_delay = 8;
    step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
    repeat (5) step(1, 0, 0);
    step(0, 0, 0);
    chk("t3_pending", o_pend, 4);
    chk("t3_overflow", int'(o_ovf), 1);
    run_idle("t3_idle", 400);
    chk("t3_dones", n_done, 5);
    chk("t3_overflow_sticky", int'(o_ovf), 1);

    // 4: no sensor -> timeout (with optional retry), fault, clear, next entry served
    clr_counts();
    resp_en = 0; bus.product_sensor = 0; bus.coin_sensor = 0;
    on_cnt = 0;
    step(1, 0, 0);
    for (int k = 0; k < 120 && !o_fault; k++) begin
      step(0, 0, 0);
      if (o_pm) on_cnt++;
    end
    chk("t4_fault", int'(o_fault), 1);
    chk("t4_motor_cycles", on_cnt, MC * (1 + RETRIES));
    chk("t4_vend_phases", n_vph, 1 + RETRIES);
    step(0, 1, 0);
    step(0, 0, 1);
    chk("t4_pending_in_fault", o_pend, 1);
    resp_en = 1; resp_delay = 3;
    clr_counts();
    run_idle("t4_idle", 200);
    chk("t4_dones_after_clear", n_done, 1);
    chk("t4_fault_cleared", int'(o_fault), 0);

    // 5: coin sensor held high 3 cycles counts one coin; second coin needs a fresh drop
    resp_en = 0; clr_counts(); hold = 0; held = 0;
    step(0, 1, 0);
    for (int k = 0; k < 80 && (k < 3 || o_busy); k++) begin
      step(0, 0, 0);
      if (n_cph == 1 && o_hm && !held) begin held = 1; hold = 3; end
      bus.coin_sensor = (hold > 0) || (n_cph == 2 && con == 2);
      if (hold > 0) hold--;
    end
    chk("t5_coin_phases", n_cph, 2);
    chk("t5_dones", n_done, 1);
    chk("t5_idle", int'(o_busy), 0);

    // 6: reset while the hopper runs
    bus.coin_sensor = 0;
    step(0, 1, 0);
    for (int k = 0; k < 20 && !o_hm; k++) step(0, 0, 0);
    chk("t6_hopper_on", int'(o_hm), 1);
    #2 rst = 1;
    #1;
    chk("t6_hopper_off", int'(bus.hopper_motor), 0);
    chk("t6_busy", int'(bus.busy), 0);
    chk("t6_pending", int'(bus.pending), 0);
    chk("t6_done_fault_ovf", int'({bus.done, bus.fault, bus.overflow}), 0);
    step(0, 0, 0); step(0, 0, 0);
    rst = 0;

    // random traffic against the model
    rnd_en = 1;
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);
      if (k == 1500) begin
        #2 rst = 1;
        step(0, 0, 0);
        rst = 0;
      end
    end
    rnd_en = 0;
    step(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
